// File: rtl/gerenciador_pedidos_if.sv
// Request/queue bus of the elevator request manager: two request panels,
// the controller's pop/current-floor inputs and the queue status outputs.
interface gerenciador_pedidos_if #(
  parameter int PROFUNDIDADE  = 8,
  parameter int LARGURA_ANDAR = 3
);
  logic                             pedidoInterno_valido;
  logic [LARGURA_ANDAR-1:0]         pedidoInterno_andar;
  logic                             pedidoInterno_aceito;
  logic                             pedidoExterno_valido;
  logic [LARGURA_ANDAR-1:0]         pedidoExterno_andar;
  logic                             pedidoExterno_aceito;
  logic                             shift;
  logic [LARGURA_ANDAR-1:0]         andarAtual;
  logic                             temDestino;
  logic [LARGURA_ANDAR-1:0]         destino;
  logic                             sobe;
  logic                             cheia;
  logic [$clog2(PROFUNDIDADE):0]    ocupacao;
  logic                             descartado;

  modport master (
    output pedidoInterno_valido, pedidoInterno_andar,
    output pedidoExterno_valido, pedidoExterno_andar,
    output shift, andarAtual,
    input  pedidoInterno_aceito, pedidoExterno_aceito,
    input  temDestino, destino, sobe, cheia, ocupacao, descartado
  );

  modport slave (
    input  pedidoInterno_valido, pedidoInterno_andar,
    input  pedidoExterno_valido, pedidoExterno_andar,
    input  shift, andarAtual,
    output pedidoInterno_aceito, pedidoExterno_aceito,
    output temDestino, destino, sobe, cheia, ocupacao, descartado
  );
endinterface

// File: rtl/gerenciador_pedidos.sv
// Elevator request queue: circular FIFO fed by cabin and hall panels with
// round-robin arbitration and duplicate-floor suppression.
module gerenciador_pedidos #(
  parameter int PROFUNDIDADE  = 8,
  parameter int LARGURA_ANDAR = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  gerenciador_pedidos_if.slave  ped
);
  localparam int PW = $clog2(PROFUNDIDADE);

  logic [LARGURA_ANDAR-1:0] fila [PROFUNDIDADE];
  logic [PW-1:0]            wrPtr, rdPtr;
  logic [PW:0]              ocup;
  logic                     rrExterno;
  logic                     descartadoQ;

  logic                     cheia, livreInt, livreExt;
  logic                     grantInt, grantExt, grant, dup, escreve, pop;
  logic [LARGURA_ANDAR-1:0] andarGrant;
  logic [PROFUNDIDADE-1:0]  igual;

  // Fullness is taken from registered state, so a same-cycle pop never frees a slot early.
  assign cheia    = (ocup == (PW+1)'(PROFUNDIDADE));
  assign livreInt = ped.pedidoInterno_valido & ~cheia & reset;
  assign livreExt = ped.pedidoExterno_valido & ~cheia & reset;
  assign grantInt = livreInt & (~livreExt | ~rrExterno);
  assign grantExt = livreExt & (~livreInt |  rrExterno);
  assign grant    = grantInt | grantExt;
  assign andarGrant = grantExt ? ped.pedidoExterno_andar : ped.pedidoInterno_andar;

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    igual = '0;
    for (int i = 0; i < PROFUNDIDADE; i++)
      igual[i] = ({1'b0, PW'(i) - rdPtr} < ocup) && (fila[i] == andarGrant);
  end

  assign dup     = |igual;
  assign escreve = grant & ~dup;
  assign pop     = ped.shift & (ocup != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      ocup        <= '0;
      rrExterno   <= 1'b0;
      descartadoQ <= 1'b0;
      for (int i = 0; i < PROFUNDIDADE; i++) fila[i] <= '0;
    end else begin
      descartadoQ <= grant & dup;
      if (escreve) begin
        fila[wrPtr] <= andarGrant;
        wrPtr       <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      case ({escreve, pop})
        2'b10:   ocup <= ocup + 1'b1;
        2'b01:   ocup <= ocup - 1'b1;
        default: ;
      endcase
      // Only contested cycles move the priority, toward the panel that lost.
      if (livreInt & livreExt) rrExterno <= grantInt;
    end
  end

  assign ped.pedidoInterno_aceito = grantInt;
  assign ped.pedidoExterno_aceito = grantExt;
  assign ped.temDestino = (ocup != '0);
  assign ped.destino    = ped.temDestino ? fila[rdPtr] : '0;
  assign ped.sobe       = (ped.destino > ped.andarAtual);
  assign ped.cheia      = cheia;
  assign ped.ocupacao   = ocup;
  assign ped.descartado = descartadoQ;
endmodule

// File: doc/gerenciador_pedidos.md
GERENCIADOR_PEDIDOS -- requirements
Module: gerenciador_pedidos

Interface
REQ-001 Parameter PROFUNDIDADE, default 8, SHALL set the queue depth in entries (power of two, 2..16).
REQ-002 Parameter LARGURA_ANDAR, default 3, SHALL set the floor-number width in bits.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 pedidoInterno_valido  input  1  SHALL flag a cabin-panel request; held high until accepted.
REQ-006 pedidoInterno_andar  input  LARGURA_ANDAR  SHALL carry the requested floor for the cabin panel.
REQ-007 pedidoInterno_aceito  output  1  SHALL be the combinational grant to the cabin panel.
REQ-008 pedidoExterno_valido / pedidoExterno_andar / pedidoExterno_aceito SHALL mirror REQ-005..007 for the hall panel.
REQ-009 shift  input  1  SHALL be the pop request from the elevator controller, consuming the head entry.
REQ-010 andarAtual  input  LARGURA_ANDAR  SHALL carry the current floor.
REQ-011 temDestino  output  1  SHALL be high whenever the queue is non-empty.
REQ-012 destino  output  LARGURA_ANDAR  SHALL present the head entry (0 when empty).
REQ-013 sobe  output  1  SHALL be high when destino > andarAtual (unsigned), else low.
REQ-014 cheia  output  1  SHALL be high when occupancy equals PROFUNDIDADE.
REQ-015 ocupacao  output  clog2(PROFUNDIDADE)+1  SHALL report the stored entry count.
REQ-016 descartado  output  1  SHALL pulse high one cycle after a granted request is dropped as duplicate.

Function
REQ-017 Queue SHALL be a circular FIFO: write pointer, read pointer, occupancy counter; pointers wrap modulo PROFUNDIDADE.
REQ-018 At most one request SHALL be granted per cycle.
REQ-019 Grant SHALL require valido=1 and cheia=0, with cheia evaluated before any same-cycle pop.
REQ-020 When exactly one panel is valid and not full, that panel SHALL be granted.
REQ-021 When both are valid and not full, a round-robin bit SHALL pick the panel not granted in the last contested cycle; the bit toggles only on contested grants.
REQ-022 A granted request whose floor equals any currently stored entry (head included, even if popped in the same cycle) SHALL be accepted but not written; descartado pulses next cycle; occupancy unchanged by it.
REQ-023 A granted non-duplicate request SHALL be written at the write pointer on the grant edge; it becomes visible on destino one cycle later if the queue was empty.
REQ-024 shift with occupancy>0 SHALL advance the read pointer and decrement occupancy; shift with occupancy=0 SHALL be ignored.
REQ-025 Simultaneous non-duplicate write and pop SHALL leave occupancy unchanged and move both pointers.
REQ-026 temDestino, destino, sobe, cheia, ocupacao SHALL derive combinationally from registered state and andarAtual (zero-latency).
REQ-027 aceito SHALL never be high while the matching valido is low.

Reset
REQ-028 reset low SHALL immediately clear pointers, occupancy, storage (to 0), descartado, and set the round-robin bit to favour pedidoInterno.
REQ-029 While reset is low, aceito outputs SHALL be 0 and temDestino 0; operation resumes on the first rising edge after release.
REQ-030 Reset asserted mid-operation SHALL discard all queued requests without completing any in-flight write.

Verification
REQ-031 Reset release, Interno valid floor 5, andarAtual 2 -> aceito same cycle; next cycle temDestino=1, destino=5, sobe=1, ocupacao=1.
REQ-032 Both valid (Interno 3, Externo 6) from reset, held -> cycle1 Interno granted, cycle2 Externo granted; queue order 3,6.
REQ-033 Queue holds floor 4, Externo requests 4 -> aceito=1, descartado=1 next cycle, ocupacao stays 1.
REQ-034 Fill 8 distinct floors -> cheia=1, further valido gets aceito=0; assert shift with valido -> pop only, request granted the following cycle.
REQ-035 shift on empty queue -> ocupacao stays 0, pointers unchanged; then write floor 1 with andarAtual 1 -> sobe=0.
REQ-036 Queue with 3 entries, pulse reset low between edges -> outputs clear immediately, temDestino=0, ocupacao=0.
